// File: rtl/hamming_secded_codec.sv
// Extended-Hamming (SECDED) encoder and decoder, each a one-deep valid/ready pipeline
// stage, with saturating corrected/uncorrectable word counters.
module hamming_secded_codec #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int P = ((DATA_W + 4)  <= 8)   ? 3 :
                       ((DATA_W + 5)  <= 16)  ? 4 :
                       ((DATA_W + 6)  <= 32)  ? 5 :
                       ((DATA_W + 7)  <= 64)  ? 6 :
                       ((DATA_W + 8)  <= 128) ? 7 :
                       ((DATA_W + 9)  <= 256) ? 8 : 9,
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [DATA_W-1:0] enc_data,
    output logic              enc_ovalid,
    input  logic              enc_oready,
    output logic [CODE_W-1:0] enc_code,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [CODE_W-1:0] dec_code,
    output logic              dec_ovalid,
    input  logic              dec_oready,
    output logic [DATA_W-1:0] dec_data,
    output logic              dec_sgl,
    output logic              dec_dbl,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sgl_cnt,
    output logic [CNT_W-1:0]  dbl_cnt
);

    localparam logic [P-1:0]     MAX_POS_C = P'(CODE_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    function automatic logic is_pow2(input int pos);
        return ((pos & (pos - 1)) == 0);
    endfunction

    function automatic logic [CODE_W-1:0] secded_encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic              p_v;
        int                j;
        c = {CODE_W{1'b0}};
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if (!is_pow2(i)) begin
                c[i] = d[j];
                j    = j + 1;
            end else begin
                c[i] = 1'b0;
            end
        end
        // Parity slots are still zero here, so XOR over all positions with bit k set is safe.
        for (int k = 0; k < P; k++) begin
            p_v = 1'b0;
            for (int i = 1; i < CODE_W; i++) begin
                p_v = p_v ^ (i[k] ? c[i] : 1'b0);
            end
            c[1 << k] = p_v;
        end
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    function automatic logic [P-1:0] secded_syndrome(input logic [CODE_W-1:0] c);
        logic [P-1:0] s;
        s = {P{1'b0}};
        for (int i = 1; i < CODE_W; i++) begin
            s = s ^ (c[i] ? P'(i) : {P{1'b0}});
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] secded_extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int                j;
        d = {DATA_W{1'b0}};
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if (!is_pow2(i)) begin
                d[j] = c[i];
                j    = j + 1;
            end
        end
        return d;
    endfunction

    logic              enc_xfer_s;
    logic [CODE_W-1:0] enc_word_s;
    logic              enc_ovalid_r;
    logic [CODE_W-1:0] enc_code_r;

    logic              dec_xfer_s;
    logic [P-1:0]      dec_syn_s;
    logic              dec_par_s;
    logic [CODE_W-1:0] dec_fix_s;
    logic [DATA_W-1:0] dec_word_s;
    logic              dec_sgl_s;
    logic              dec_dbl_s;
    logic              dec_ovalid_r;
    logic [DATA_W-1:0] dec_data_r;
    logic              dec_sgl_r;
    logic              dec_dbl_r;
    logic [CNT_W-1:0]  sgl_cnt_r;
    logic [CNT_W-1:0]  dbl_cnt_r;

    assign enc_ready  = !enc_ovalid_r || enc_oready;
    assign enc_xfer_s = enc_valid && enc_ready;
    assign dec_ready  = !dec_ovalid_r || dec_oready;
    assign dec_xfer_s = dec_valid && dec_ready;

    // Encoder codeword generation.
    always_comb begin
        enc_word_s = secded_encode(enc_data);
    end

    // Decoder syndrome classification and single-bit correction.
    always_comb begin
        dec_syn_s = secded_syndrome(dec_code);
        dec_par_s = ^dec_code;
        dec_fix_s = dec_code;
        dec_sgl_s = 1'b0;
        dec_dbl_s = 1'b0;
        if (dec_syn_s == {P{1'b0}}) begin
            dec_sgl_s = dec_par_s;
        end else if (!dec_par_s) begin
            dec_dbl_s = 1'b1;
        end else if (dec_syn_s <= MAX_POS_C) begin
            dec_fix_s[dec_syn_s] = ~dec_code[dec_syn_s];
            dec_sgl_s            = 1'b1;
        end else begin
            dec_dbl_s = 1'b1;
        end
        dec_word_s = secded_extract(dec_fix_s);
    end

    // Encoder output stage: load on transfer, hold under backpressure.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            enc_ovalid_r <= 1'b0;
            enc_code_r   <= {CODE_W{1'b0}};
        end else if (enc_xfer_s) begin
            enc_ovalid_r <= 1'b1;
            enc_code_r   <= enc_word_s;
        end else if (enc_oready) begin
            enc_ovalid_r <= 1'b0;
        end
    end

    // Decoder output stage: data and flags move together.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            dec_ovalid_r <= 1'b0;
            dec_data_r   <= {DATA_W{1'b0}};
            dec_sgl_r    <= 1'b0;
            dec_dbl_r    <= 1'b0;
        end else if (dec_xfer_s) begin
            dec_ovalid_r <= 1'b1;
            dec_data_r   <= dec_word_s;
            dec_sgl_r    <= dec_sgl_s;
            dec_dbl_r    <= dec_dbl_s;
        end else if (dec_oready) begin
            dec_ovalid_r <= 1'b0;
        end
    end

    // Saturating error counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sgl_cnt_r <= {CNT_W{1'b0}};
            dbl_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            sgl_cnt_r <= {CNT_W{1'b0}};
            dbl_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (dec_xfer_s && dec_sgl_s && (sgl_cnt_r != CNT_MAX_C)) begin
                sgl_cnt_r <= sgl_cnt_r + CNT_W'(1);
            end
            if (dec_xfer_s && dec_dbl_s && (dbl_cnt_r != CNT_MAX_C)) begin
                dbl_cnt_r <= dbl_cnt_r + CNT_W'(1);
            end
        end
    end

    assign enc_ovalid = enc_ovalid_r;
    assign enc_code   = enc_code_r;
    assign dec_ovalid = dec_ovalid_r;
    assign dec_data   = dec_data_r;
    assign dec_sgl    = dec_sgl_r;
    assign dec_dbl    = dec_dbl_r;
    assign sgl_cnt    = sgl_cnt_r;
    assign dbl_cnt    = dbl_cnt_r;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed bench for hamming_secded_codec: vector tables for encode/decode plus
// hand sequences for backpressure, counter saturation/clear and mid-stream reset.
module tb_hamming_secded_codec;

    logic        clk = 1'b0;
    logic        arstn;
    logic        enc_valid, enc_oready, dec_valid, dec_oready, cnt_clr;
    logic [7:0]  enc_data;
    logic [12:0] dec_code;
    logic        enc_ready, enc_ovalid, dec_ready, dec_ovalid, dec_sgl, dec_dbl;
    logic [12:0] enc_code;
    logic [7:0]  dec_data;
    logic [15:0] sgl_cnt, dbl_cnt;

    logic        s_enc_valid, s_enc_oready, s_dec_valid, s_dec_oready, s_cnt_clr;
    logic [7:0]  s_enc_data;
    logic [12:0] s_dec_code;
    logic        s_enc_ready, s_enc_ovalid, s_dec_ready, s_dec_ovalid, s_dec_sgl, s_dec_dbl;
    logic [12:0] s_enc_code;
    logic [7:0]  s_dec_data;
    logic [1:0]  s_sgl_cnt, s_dbl_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_secded_codec #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .arstn(arstn),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data),
        .enc_ovalid(enc_ovalid), .enc_oready(enc_oready), .enc_code(enc_code),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_code(dec_code),
        .dec_ovalid(dec_ovalid), .dec_oready(dec_oready), .dec_data(dec_data),
        .dec_sgl(dec_sgl), .dec_dbl(dec_dbl),
        .cnt_clr(cnt_clr), .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a few words.
    hamming_secded_codec #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .arstn(arstn),
        .enc_valid(s_enc_valid), .enc_ready(s_enc_ready), .enc_data(s_enc_data),
        .enc_ovalid(s_enc_ovalid), .enc_oready(s_enc_oready), .enc_code(s_enc_code),
        .dec_valid(s_dec_valid), .dec_ready(s_dec_ready), .dec_code(s_dec_code),
        .dec_ovalid(s_dec_ovalid), .dec_oready(s_dec_oready), .dec_data(s_dec_data),
        .dec_sgl(s_dec_sgl), .dec_dbl(s_dec_dbl),
        .cnt_clr(s_cnt_clr), .sgl_cnt(s_sgl_cnt), .dbl_cnt(s_dbl_cnt)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic [12:0] code;
    } enc_vec_t;

    typedef struct packed {
        logic [12:0] code;
        logic [7:0]  data;
        logic        sgl;
        logic        dbl;
    } dec_vec_t;

    enc_vec_t enc_tab [5];
    dec_vec_t dec_tab [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int       exp_sgl, exp_dbl, idx, got;
        logic [7:0]  q[$];
        logic [12:0] scode [4];
        logic [7:0]  sdat [4];
        logic [1:0]  sat_exp [4];

        enc_tab[0] = '{8'hA5, 13'h144E};
        enc_tab[1] = '{8'h00, 13'h0000};
        enc_tab[2] = '{8'hFF, 13'h1EEE};
        enc_tab[3] = '{8'h01, 13'h000F};
        enc_tab[4] = '{8'h80, 13'h1111};

        dec_tab[0]  = '{13'h144E, 8'hA5, 1'b0, 1'b0};
        dec_tab[1]  = '{13'h140E, 8'hA5, 1'b1, 1'b0};
        dec_tab[2]  = '{13'h144F, 8'hA5, 1'b1, 1'b0};
        dec_tab[3]  = '{13'h1466, 8'hA6, 1'b0, 1'b1};
        dec_tab[4]  = '{13'h044E, 8'hA5, 1'b1, 1'b0};
        dec_tab[5]  = '{13'h144C, 8'hA5, 1'b1, 1'b0};
        dec_tab[6]  = '{13'h155C, 8'hA5, 1'b0, 1'b1};
        dec_tab[7]  = '{13'h1447, 8'hA4, 1'b0, 1'b1};
        dec_tab[8]  = '{13'h0000, 8'h00, 1'b0, 1'b0};
        dec_tab[9]  = '{13'h1EEE, 8'hFF, 1'b0, 1'b0};
        dec_tab[10] = '{13'h000F, 8'h01, 1'b0, 1'b0};
        dec_tab[11] = '{13'h1111, 8'h80, 1'b0, 1'b0};

        scode = '{13'h144E, 13'h1EEE, 13'h000F, 13'h1111};
        sdat  = '{8'hA5, 8'hFF, 8'h01, 8'h80};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3};

        arstn = 1'b0;
        enc_valid = 1'b0; enc_oready = 1'b0; enc_data = 8'h00;
        dec_valid = 1'b0; dec_oready = 1'b0; dec_code = 13'h0000; cnt_clr = 1'b0;
        s_enc_valid = 1'b0; s_enc_oready = 1'b0; s_enc_data = 8'h00;
        s_dec_valid = 1'b0; s_dec_oready = 1'b0; s_dec_code = 13'h0000; s_cnt_clr = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_enc_ovalid", enc_ovalid, 0);
        check("rst_enc_code", enc_code, 0);
        check("rst_enc_ready", enc_ready, 1);
        check("rst_dec_ready", dec_ready, 1);
        check("rst_dec_ovalid", dec_ovalid, 0);
        check("rst_dec_flags", {dec_data, dec_sgl, dec_dbl}, 0);
        check("rst_counters", {sgl_cnt, dbl_cnt}, 0);
        arstn = 1'b1;
        @(negedge clk);

        // Encoder table at full throughput
        enc_oready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enc_valid = 1'b1;
            enc_data  = enc_tab[i].data;
            @(negedge clk);
            check($sformatf("enc%0d_ovalid", i), enc_ovalid, 1);
            check($sformatf("enc%0d_code", i), enc_code, enc_tab[i].code);
        end
        enc_valid = 1'b0;
        @(negedge clk);
        check("enc_idle_ovalid", enc_ovalid, 0);

        // Encoder backpressure: output held, next word waits
        enc_oready = 1'b0;
        enc_valid  = 1'b1;
        enc_data   = 8'h01;
        @(negedge clk);
        check("encbp_ovalid", enc_ovalid, 1);
        check("encbp_ready_low", enc_ready, 0);
        enc_data = 8'h80;
        @(negedge clk);
        check("encbp_hold_code", enc_code, 13'h000F);
        enc_oready = 1'b1;
        #1;
        check("encbp_ready_high", enc_ready, 1);
        @(negedge clk);
        check("encbp_next_code", enc_code, 13'h1111);
        enc_valid = 1'b0;
        @(negedge clk);

        // Decoder table with counter tracking
        exp_sgl = 0;
        exp_dbl = 0;
        dec_oready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            dec_valid = 1'b1;
            dec_code  = dec_tab[i].code;
            exp_sgl  += int'(dec_tab[i].sgl);
            exp_dbl  += int'(dec_tab[i].dbl);
            @(negedge clk);
            check($sformatf("dec%0d_ovalid", i), dec_ovalid, 1);
            check($sformatf("dec%0d_data", i), dec_data, dec_tab[i].data);
            check($sformatf("dec%0d_sgl", i), dec_sgl, dec_tab[i].sgl);
            check($sformatf("dec%0d_dbl", i), dec_dbl, dec_tab[i].dbl);
            check($sformatf("dec%0d_sgl_cnt", i), sgl_cnt, exp_sgl);
            check($sformatf("dec%0d_dbl_cnt", i), dbl_cnt, exp_dbl);
        end
        dec_valid = 1'b0;
        @(negedge clk);
        check("dec_idle_ovalid", dec_ovalid, 0);

        // Four-word stream with a 3-cycle downstream stall
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            dec_oready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (dec_ovalid) begin
                check("stream_expected_word", q.size() != 0, 1);
                if (q.size() != 0) begin
                    check($sformatf("stream_c%0d_data", cyc), dec_data, q[0]);
                    if (dec_oready) begin
                        void'(q.pop_front());
                        got++;
                    end else begin
                        check($sformatf("stream_c%0d_ready", cyc), dec_ready, 0);
                    end
                end
            end
            if (idx < 4) begin
                dec_valid = 1'b1;
                dec_code  = scode[idx];
                #1;
                if (dec_ready) begin
                    q.push_back(sdat[idx]);
                    idx++;
                end
            end else begin
                dec_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("stream_received", got, 4);
        check("stream_sgl_cnt", sgl_cnt, exp_sgl);
        dec_valid  = 1'b0;
        dec_oready = 1'b1;
        @(negedge clk);

        // Counter saturation and clear priority on the narrow instance
        s_dec_oready = 1'b1;
        s_dec_valid  = 1'b1;
        s_dec_code   = 13'h140E;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("sat%0d_sgl_cnt", i), s_sgl_cnt, sat_exp[i]);
        end
        s_cnt_clr = 1'b1;
        @(negedge clk);
        check("sat_clr_sgl_cnt", s_sgl_cnt, 0);
        check("sat_clr_dec_sgl", s_dec_sgl, 1);
        s_cnt_clr   = 1'b0;
        s_dec_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of traffic
        enc_valid = 1'b1; enc_data = 8'hA5;
        dec_valid = 1'b1; dec_code = 13'h140E;
        @(negedge clk);
        check("mid_pre_enc_ovalid", enc_ovalid, 1);
        check("mid_pre_sgl_cnt", sgl_cnt, exp_sgl + 1);
        #2;
        arstn = 1'b0;
        #1;
        check("mid_enc_ovalid", enc_ovalid, 0);
        check("mid_enc_code", enc_code, 0);
        check("mid_dec_ovalid", dec_ovalid, 0);
        check("mid_dec_out", {dec_data, dec_sgl, dec_dbl}, 0);
        check("mid_counters", {sgl_cnt, dbl_cnt}, 0);
        check("mid_readies", {enc_ready, dec_ready}, 2'b11);
        @(negedge clk);
        check("mid_held_ovalid", {enc_ovalid, dec_ovalid}, 0);
        arstn = 1'b1;
        @(negedge clk);
        check("post_enc_code", enc_code, 13'h144E);
        check("post_dec_data", dec_data, 8'hA5);
        check("post_sgl_cnt", sgl_cnt, 1);
        enc_valid = 1'b0;
        dec_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
